hazard_ctrl_ms: RTL

Parametrised, sequential successor to the single-cycle load-use detector. It sits in the ID stage of the 5-stage pipeline and drives PC/IF-ID write enables, ID/EX bubble insertion and IF/ID flush. It supports:
- configurable load-use bubble depth;
- per-operand use qualifiers and R0 exemption;
- whole-pipeline freeze while data memory is not ready;
- taken-branch flush;
- a saturating stall-cycle performance counter.

---
 rtl/hazard_ctrl_ms.sv | 135 +++++++++++++
 1 files changed

// File: rtl/hazard_ctrl_ms.sv
// ID-stage hazard controller: load-use bubbles of configurable depth, memory-wait freeze,
// taken-branch IF/ID flush and a saturating stall-cycle counter.
module hazard_ctrl_ms #(
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned LOAD_STALL  = 1,
  parameter int unsigned ZERO_EXEMPT = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_ex_memread_i,
  input  logic [ADDR_W-1:0] id_ex_rt_i,
  input  logic [ADDR_W-1:0] if_id_rs_i,
  input  logic [ADDR_W-1:0] if_id_rt_i,
  input  logic              if_id_use_rs_i,
  input  logic              if_id_use_rt_i,
  input  logic              mem_req_i,
  input  logic              mem_ready_i,
  input  logic              branch_taken_i,
  output logic              pc_write_o,
  output logic              if_id_write_o,
  output logic              bubble_o,
  output logic              freeze_o,
  output logic              if_id_flush_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  typedef enum logic [1:0] {StRun, StBubble, StMemWait} state_e;

  localparam logic [3:0] BubbleInit = 4'(LOAD_STALL - 1);

  state_e           state_q, state_d;
  logic [3:0]       bcnt_q, bcnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic rs_zero, rt_zero, rs_hit, rt_hit, hz, mem_wait;
  logic pc_w, ifid_w, bubble, freeze;

  assign rs_zero  = (ZERO_EXEMPT != 0) && (if_id_rs_i == '0);
  assign rt_zero  = (ZERO_EXEMPT != 0) && (if_id_rt_i == '0);
  assign rs_hit   = if_id_use_rs_i && (id_ex_rt_i == if_id_rs_i) && !rs_zero;
  assign rt_hit   = if_id_use_rt_i && (id_ex_rt_i == if_id_rt_i) && !rt_zero;
  assign hz       = id_ex_memread_i && (rs_hit || rt_hit);
  assign mem_wait = mem_req_i && !mem_ready_i;

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    pc_w    = 1'b1;
    ifid_w  = 1'b1;
    bubble  = 1'b0;
    freeze  = 1'b0;
    unique case (state_q)
      StRun: begin
        if (mem_wait) begin
          // Freeze wins over a concurrent hazard; hz is re-checked once the pipe moves.
          freeze  = 1'b1;
          pc_w    = 1'b0;
          ifid_w  = 1'b0;
          state_d = StMemWait;
        end else if (hz) begin
          bubble = 1'b1;
          pc_w   = 1'b0;
          ifid_w = 1'b0;
          if (LOAD_STALL > 1) begin
            state_d = StBubble;
            bcnt_d  = BubbleInit;
          end
        end
      end
      StBubble: begin
        pc_w   = 1'b0;
        ifid_w = 1'b0;
        if (mem_wait) begin
          freeze  = 1'b1;
          state_d = StMemWait;
        end else begin
          bubble = 1'b1;
          bcnt_d = bcnt_q - 4'd1;
          if (bcnt_q <= 4'd1) begin
            state_d = StRun;
            bcnt_d  = 4'd0;
          end
        end
      end
      StMemWait: begin
        freeze = 1'b1;
        pc_w   = 1'b0;
        ifid_w = 1'b0;
        if (mem_ready_i) begin
          state_d = (bcnt_q != 4'd0) ? StBubble : StRun;
        end
      end
      default: begin
        state_d = StRun;
        bcnt_d  = 4'd0;
      end
    endcase

    // Outputs read as free-running while reset is held.
    if (!rst_i) begin
      pc_w   = 1'b1;
      ifid_w = 1'b1;
      bubble = 1'b0;
      freeze = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (!pc_w && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StRun;
      bcnt_q  <= 4'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc_write_o    = pc_w;
  assign if_id_write_o = ifid_w;
  assign bubble_o      = bubble;
  assign freeze_o      = freeze;
  assign if_id_flush_o = branch_taken_i && pc_w && rst_i;
  assign stall_cnt_o   = cnt_q;

endmodule
